// File: rtl/mips_pkg.sv
// Shared opcodes, funct codes and ALU control encoding for the MIPS EX/MEM datapath.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;

    // Primary opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_t;

endpackage

// File: rtl/mips_dmem.sv
// Word-addressed data memory: async clear on reset, SW write on clock edge,
// combinational LW read (zero when the MEM-stage op is not a load).
module mips_dmem
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned DMEM_AW    = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [OP_W-1:0]   mem_op,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata
);

    logic [DATA_W-1:0]  r_mem [DMEM_DEPTH];
    logic [DMEM_AW-1:0] w_idx;
    logic               w_unused_addr;

    // Byte address to word index; upper bits wrap, byte offset ignored
    assign w_idx         = mem_addr[DMEM_AW+1:2];
    assign w_unused_addr = ^{mem_addr[DATA_W-1:DMEM_AW+2], mem_addr[1:0]};

    // Store port with asynchronous clear of the whole array
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (mem_op == OP_SW) begin
            r_mem[w_idx] <= mem_wdata;
        end
    end

    // Load data is only presented for LW so the WB mux sees zero otherwise
    always_comb begin
        mem_rdata = '0;
        if (mem_op == OP_LW) begin
            mem_rdata = r_mem[w_idx];
        end
    end

endmodule

// File: rtl/mips_exec_mem_unit.sv
// EX/MEM datapath slice of the 5-stage MIPS pipeline: ALU-control decoder,
// 32-bit ALU with an EX/MEM result register, and the data memory.
// Optional build macro ALU_OVERFLOW_EN adds signed-overflow outputs alu_ovf/alu_ovf_q.
module mips_exec_mem_unit
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned DMEM_AW    = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OP_W-1:0]     ex_op,
    input  logic [FUNCT_W-1:0]  ex_funct,
    input  logic [DATA_W-1:0]   alu_a,
    input  logic [DATA_W-1:0]   alu_b,
    output logic [2:0]          alu_ctrl,
    output logic [DATA_W-1:0]   alu_result,
    output logic [DATA_W-1:0]   alu_result_q,
    output logic                alu_zero,
    input  logic [OP_W-1:0]     mem_op,
    input  logic [DATA_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata
`ifdef ALU_OVERFLOW_EN
    ,
    output logic                alu_ovf,
    output logic                alu_ovf_q
`endif
);

    alu_ctrl_t         w_alu_ctrl;
    logic [DATA_W-1:0] w_alu_result;
    logic [DATA_W-1:0] r_alu_result_q;

    // Opcode/funct to ALU operation; anything unrecognised falls back to ADD
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (ex_op)
            OP_RTYPE: begin
                case (ex_funct)
                    FN_ADD, FN_ADDU: w_alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: w_alu_ctrl = ALU_SUB;
                    FN_AND:          w_alu_ctrl = ALU_AND;
                    FN_OR:           w_alu_ctrl = ALU_OR;
                    FN_XOR:          w_alu_ctrl = ALU_XOR;
                    FN_NOR:          w_alu_ctrl = ALU_NOR;
                    FN_SLT:          w_alu_ctrl = ALU_SLT;
                    FN_JR:           w_alu_ctrl = ALU_ADD;
                    default:         w_alu_ctrl = ALU_ADD;
                endcase
            end
            OP_BEQ:                          w_alu_ctrl = ALU_SUB;
            OP_LW, OP_SW, OP_ADDI:           w_alu_ctrl = ALU_ADD;
            OP_J, OP_JAL:                    w_alu_ctrl = ALU_ADD;
            default:                         w_alu_ctrl = ALU_ADD;
        endcase
    end

    // ALU: wrapping add/sub, signed set-less-than, bitwise ops
    always_comb begin
        w_alu_result = alu_a + alu_b;
        case (w_alu_ctrl)
            ALU_AND: w_alu_result = alu_a & alu_b;
            ALU_OR:  w_alu_result = alu_a | alu_b;
            ALU_ADD: w_alu_result = alu_a + alu_b;
            ALU_XOR: w_alu_result = alu_a ^ alu_b;
            ALU_NOR: w_alu_result = ~(alu_a | alu_b);
            ALU_SUB: w_alu_result = alu_a - alu_b;
            ALU_SLT: w_alu_result = ($signed(alu_a) < $signed(alu_b)) ? DATA_W'(1) : '0;
            default: w_alu_result = alu_a + alu_b;
        endcase
    end

    assign alu_ctrl   = w_alu_ctrl;
    assign alu_result = w_alu_result;
    assign alu_zero   = (w_alu_result == '0);

    // EX/MEM result register; stalls are handled upstream so no enable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alu_result_q <= '0;
        end else begin
            r_alu_result_q <= w_alu_result;
        end
    end

    assign alu_result_q = r_alu_result_q;

`ifdef ALU_OVERFLOW_EN
    logic w_alu_ovf;
    logic r_alu_ovf_q;

    // Signed overflow: ADD with like-signed operands, SUB with unlike-signed operands
    always_comb begin
        w_alu_ovf = 1'b0;
        case (w_alu_ctrl)
            ALU_ADD: w_alu_ovf = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                                 (w_alu_result[DATA_W-1] != alu_a[DATA_W-1]);
            ALU_SUB: w_alu_ovf = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                                 (w_alu_result[DATA_W-1] != alu_a[DATA_W-1]);
            default: w_alu_ovf = 1'b0;
        endcase
    end

    // Overflow flag travels with the registered result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alu_ovf_q <= 1'b0;
        end else begin
            r_alu_ovf_q <= w_alu_ovf;
        end
    end

    assign alu_ovf   = w_alu_ovf;
    assign alu_ovf_q = r_alu_ovf_q;
`endif

    mips_dmem #(
        .DATA_W     (DATA_W),
        .DMEM_DEPTH (DMEM_DEPTH),
        .DMEM_AW    (DMEM_AW)
    ) u_dmem (
        .clock     (clock),
        .reset     (reset),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Directed bench for mips_exec_mem_unit: ALU vector table plus memory/reset sequences.
module tb_mips_exec_mem_unit;

    logic        clock;
    logic        reset;
    logic [5:0]  ex_op;
    logic [5:0]  ex_funct;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [31:0] alu_result_q;
    logic        alu_zero;
    logic [5:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef ALU_OVERFLOW_EN
    logic        alu_ovf;
    logic        alu_ovf_q;
`endif

    int checks = 0;
    int errors = 0;

    mips_exec_mem_unit dut (
        .clock        (clock),
        .reset        (reset),
        .ex_op        (ex_op),
        .ex_funct     (ex_funct),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_result_q (alu_result_q),
        .alu_zero     (alu_zero),
        .mem_op       (mem_op),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
`ifdef ALU_OVERFLOW_EN
        ,
        .alu_ovf      (alu_ovf),
        .alu_ovf_q    (alu_ovf_q)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        // op, funct, a, b, ctrl, result, zero, ovf
        vecs[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,        3'b010, 32'd12,       1'b0, 1'b0};
        vecs[1]  = '{6'h00, 6'h22, 32'd3,        32'd5,        3'b110, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        3'b111, 32'd1,        1'b0, 1'b0};
        vecs[3]  = '{6'h00, 6'h2A, 32'd1,        32'hFFFFFFFF, 3'b111, 32'd0,        1'b1, 1'b0};
        vecs[4]  = '{6'h04, 6'h00, 32'd9,        32'd9,        3'b110, 32'd0,        1'b1, 1'b0};
        vecs[5]  = '{6'h00, 6'h24, 32'h0000F0F0, 32'h0000FF00, 3'b000, 32'h0000F000, 1'b0, 1'b0};
        vecs[6]  = '{6'h00, 6'h25, 32'h0000F0F0, 32'h00000F0F, 3'b001, 32'h0000FFFF, 1'b0, 1'b0};
        vecs[7]  = '{6'h00, 6'h26, 32'h0000FF00, 32'h00000FF0, 3'b011, 32'h0000F0F0, 1'b0, 1'b0};
        vecs[8]  = '{6'h00, 6'h27, 32'd0,        32'd0,        3'b100, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{6'h00, 6'h21, 32'hFFFFFFFF, 32'd1,        3'b010, 32'd0,        1'b1, 1'b0};
        vecs[10] = '{6'h00, 6'h23, 32'd10,       32'd3,        3'b110, 32'd7,        1'b0, 1'b0};
        vecs[11] = '{6'h00, 6'h08, 32'd2,        32'd3,        3'b010, 32'd5,        1'b0, 1'b0};
        vecs[12] = '{6'h23, 6'h2A, 32'h00000100, 32'd4,        3'b010, 32'h00000104, 1'b0, 1'b0};
        vecs[13] = '{6'h02, 6'h22, 32'd1,        32'd1,        3'b010, 32'd2,        1'b0, 1'b0};
        vecs[14] = '{6'h00, 6'h00, 32'd4,        32'd4,        3'b010, 32'd8,        1'b0, 1'b0};
        vecs[15] = '{6'h0C, 6'h24, 32'd6,        32'd1,        3'b010, 32'd7,        1'b0, 1'b0};
        vecs[16] = '{6'h00, 6'h20, 32'h7FFFFFFF, 32'd1,        3'b010, 32'h80000000, 1'b0, 1'b1};
        vecs[17] = '{6'h00, 6'h22, 32'h80000000, 32'd1,        3'b110, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[18] = '{6'h00, 6'h2A, 32'h7FFFFFFF, 32'h80000000, 3'b111, 32'd0,        1'b1, 1'b0};

        reset     = 1'b1;
        ex_op     = 6'h00;
        ex_funct  = 6'h20;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        mem_op    = 6'h00;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;

        // Reset and release
        repeat (3) @(posedge clock);
        #1;
        check("reset_alu_result_q", alu_result_q, 32'd0);
        @(negedge clock);
        reset    = 1'b0;
        mem_op   = 6'h23;
        mem_addr = 32'h40;
        #1;
        check("reset_lw_0x40", mem_rdata, 32'd0);
        mem_op = 6'h00;

        // ALU table: combinational outputs, then the registered result one edge later
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            ex_op    = vecs[i].op;
            ex_funct = vecs[i].funct;
            alu_a    = vecs[i].a;
            alu_b    = vecs[i].b;
            #1;
            check($sformatf("v%0d_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].ctrl));
            check($sformatf("v%0d_result", i), alu_result, vecs[i].res);
            check($sformatf("v%0d_zero", i), 32'(alu_zero), 32'(vecs[i].zero));
`ifdef ALU_OVERFLOW_EN
            check($sformatf("v%0d_ovf", i), 32'(alu_ovf), 32'(vecs[i].ovf));
`endif
            @(posedge clock);
            #1;
            check($sformatf("v%0d_result_q", i), alu_result_q, vecs[i].res);
`ifdef ALU_OVERFLOW_EN
            check($sformatf("v%0d_ovf_q", i), 32'(alu_ovf_q), 32'(vecs[i].ovf));
`endif
        end

        // Store then load, with address wrap and ignored byte offset
        @(negedge clock);
        mem_op    = 6'h2B;
        mem_addr  = 32'h10;
        mem_wdata = 32'hDEADBEEF;
        #1;
        check("sw_rdata_zero", mem_rdata, 32'd0);
        @(negedge clock);
        mem_addr  = 32'h14;
        mem_wdata = 32'h12345678;
        @(negedge clock);
        mem_op   = 6'h23;
        mem_addr = 32'h10;
        #1;
        check("lw_0x10", mem_rdata, 32'hDEADBEEF);
        mem_addr = 32'h1010;
        #1;
        check("lw_0x1010_wrap", mem_rdata, 32'hDEADBEEF);
        mem_addr = 32'h13;
        #1;
        check("lw_0x13_offset", mem_rdata, 32'hDEADBEEF);
        mem_addr = 32'h14;
        #1;
        check("lw_0x14", mem_rdata, 32'h12345678);

        // Non-memory op: no read data and no write
        @(negedge clock);
        mem_op    = 6'h08;
        mem_addr  = 32'h10;
        mem_wdata = 32'h0BADF00D;
        #1;
        check("addi_rdata_zero", mem_rdata, 32'd0);
        @(negedge clock);
        mem_op = 6'h23;
        #1;
        check("lw_0x10_after_addi", mem_rdata, 32'hDEADBEEF);

        // Asynchronous reset mid-cycle clears the result register immediately
        ex_op    = 6'h00;
        ex_funct = 6'h20;
        alu_a    = 32'd100;
        alu_b    = 32'd1;
        @(posedge clock);
        #1;
        check("pre_reset_q", alu_result_q, 32'd101);
        @(negedge clock);
        mem_op    = 6'h2B;
        mem_addr  = 32'h10;
        mem_wdata = 32'h11111111;
        reset     = 1'b1;
        #1;
        check("async_reset_q", alu_result_q, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        mem_op = 6'h23;
        #1;
        check("lw_0x10_after_reset", mem_rdata, 32'd0);
        mem_addr = 32'h14;
        #1;
        check("lw_0x14_after_reset", mem_rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_exec_mem_unit.md
Name: mips_exec_mem_unit

Overview:
- Execute and memory datapath for the 5-stage MIPS pipeline. Contains three parts:
  - opcode/funct ALU-control decoder;
  - 32-bit ALU with combinational and registered results;
  - word-addressed data memory.
- Sits between the forwarding muxes (ID/EX operands) and the MEM/WB register. The pipeline top keeps ownership of the IR and pipeline registers.

Parameters:
- DATA_W, 32, datapath width.
- DMEM_DEPTH, 1024, data memory depth in words (power of two).
- DMEM_AW, 10, word index width, equal to log2(DMEM_DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ex_op  in  6  opcode of the instruction in EX (IR[31:26]).
- ex_funct  in  6  funct field of the instruction in EX (IR[5:0]).
- alu_a  in  DATA_W  forwarded operand A.
- alu_b  in  DATA_W  forwarded operand B or immediate.
- alu_ctrl  out  3  decoded ALU operation.
- alu_result  out  DATA_W  combinational ALU result.
- alu_result_q  out  DATA_W  registered ALU result (EX/MEM).
- alu_zero  out  1  high when alu_result == 0.
- mem_op  in  6  opcode of the instruction in MEM.
- mem_addr  in  DATA_W  byte address (EX/MEM ALU output).
- mem_wdata  in  DATA_W  store data (EX/MEM B).
- mem_rdata  out  DATA_W  load data.

Behaviour:
- Opcodes: LW=6'h23, SW=6'h2B, BEQ=6'h04, ADDI=6'h08, R-type=6'h00, J=6'h02, JAL=6'h03.
- alu_ctrl codes: AND=000, OR=001, ADD=010, XOR=011, NOR=100, SUB=110, SLT=111.
- Decoder (combinational):
  - LW, SW, ADDI → ADD.
  - BEQ → SUB.
  - R-type funct mapping: 0x20/0x21 → ADD, 0x22/0x23 → SUB, 0x24 → AND, 0x25 → OR, 0x26 → XOR, 0x27 → NOR, 0x2A → SLT.
  - Any other funct (including JR 0x08) and any other opcode → ADD.
- ALU (combinational):
  - ADD/SUB: modulo 2^32, no trap.
  - SLT: signed two's-complement compare; result is 32'd1 if a<b, else 0.
  - NOR: ~(a|b).
  - alu_zero reflects the combinational result.
- alu_result_q:
  - Captures alu_result on every rising clock edge.
  - Resets to 0 asynchronously.
  - Latency is 1 cycle. No enable; the pipeline top handles stalls upstream.
- Data memory:
  - Index = mem_addr[DMEM_AW+1:2]. The low 2 bits are ignored. Higher bits are ignored, so addresses wrap modulo DMEM_DEPTH words.
  - Write: when mem_op==SW at a rising edge and reset is low, mem[index] <= mem_wdata.
  - Read: combinational. mem_rdata = mem[index] when mem_op==LW, else 0. A load issued the cycle after a store to the same address returns the new data.
  - Reset clears every memory word to 0 asynchronously, and writes are suppressed while reset is high. Reset asserted mid-operation discards any pending write on that edge.
- Reset values:
  - alu_result_q = 0.
  - mem_rdata = 0, since memory is cleared.
  - alu_ctrl, alu_result and alu_zero are combinational from their inputs.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- When defined:
  - Adds output port alu_ovf (1 bit).
  - alu_ovf goes high for signed overflow on ADD (operands of equal sign, result of opposite sign).
  - alu_ovf goes high for signed overflow on SUB (operands of differing sign, result sign different from a).
  - alu_ovf is low for all other operations.
  - Adds registered alu_ovf_q, reset to 0.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package mips_pkg holds:
  - opcode localparams (LW, SW, BEQ, ADDI, RTYPE, J, JAL);
  - funct localparams;
  - a 3-bit alu_ctrl_t enum with the codes above.
- One sub-module is natural: mips_dmem (memory array, write port, read mux, reset clear). Decoder and ALU stay inline in the top.

Test Plan:
- Reset, then release: alu_result_q=0, and mem_rdata=0 for LW at address 0x40.
- ex_op=0, funct=0x20, a=5, b=7 → alu_ctrl=010, alu_result=12, alu_result_q=12 one cycle later. Repeat with funct=0x22, a=3, b=5 → 0xFFFFFFFE.
- funct=0x2A, a=0xFFFFFFFF, b=1 → 1. Swap a and b → 0. ex_op=BEQ, a=b=9 → alu_ctrl=110, alu_zero=1.
- SW to mem_addr=0x10 with wdata=0xDEADBEEF, then LW at 0x10 → 0xDEADBEEF. LW at 0x1010 (wrap) → 0xDEADBEEF. LW at 0x13 → 0xDEADBEEF.
- mem_op=ADDI with addr 0x10 → mem_rdata=0 and memory unchanged. Assert reset mid-run, then LW 0x10 → 0.
- With ALU_OVERFLOW_EN: ADD 0x7FFFFFFF+1 → alu_ovf=1. SUB 0x80000000-1 → alu_ovf=1. ADD 1+1 → alu_ovf=0.
